// File: rtl/pipe_stage_hs.sv
// Handshaked (valid/ready) pipeline register; in->out latency 1 cycle, sustains 1 transfer/cycle.
// Backpressure: SKID=1 parks one extra beat and drops a registered in_ready only when full; SKID=0 forwards out_ready combinationally.
module pipe_stage_hs #(
  parameter int unsigned     DW      = 134,
  parameter logic [DW-1:0]   RST_VAL = '0,
  parameter bit              SKID    = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic          push, pop;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  // With no skid entry the only way to accept while full is to drain in the same cycle.
  assign in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = RST_VAL;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = RST_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RST_VAL;
          skid_d  = RST_VAL;
        end
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= RST_VAL;
      skid_q     <= RST_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: one SKID=1 and one SKID=0 instance checked every cycle against a queue model.
// Directed reset/stream/stall/flush/drain/no-skid scenarios, then randomized traffic with flushes.
module tb_pipe_stage_hs;

  localparam int DW = 134;
  localparam logic [DW-1:0] RV1 = {6'h00, 32'h0000_0013, 96'h0};
  localparam logic [DW-1:0] RV0 = '0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fl1, iv1, ir1, ov1, or1;
  logic [DW-1:0] id1, od1;
  logic [1:0]    occ1;
  logic          fl0, iv0, ir0, ov0, or0;
  logic [DW-1:0] id0, od0;
  logic [1:0]    occ0;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_hs #(.DW(DW), .RST_VAL(RV1), .SKID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1)
  );

  pipe_stage_hs #(.DW(DW), .RST_VAL(RV0), .SKID(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(fl0),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(occ0)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {6'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; id1 = '0;
    fl0 = 1'b0; iv0 = 1'b0; or0 = 1'b0; id0 = '0;
  endtask

  // One clock of traffic on the selected instance (1 = skid, 0 = no skid); call at negedge.
  task automatic cycle(input bit sel, input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
    logic [DW-1:0] exp_d;
    int            n;
    bit            exp_rdy, push, pop;
    idle_inputs();
    if (sel) begin
      fl1 = fl; iv1 = iv; id1 = d; or1 = ordy;
    end else begin
      fl0 = fl; iv0 = iv; id0 = d; or0 = ordy;
    end
    #1;
    n       = sel ? q1.size() : q0.size();
    exp_rdy = sel ? (n < 2) : (n == 0 || ordy);
    exp_d   = sel ? RV1 : RV0;
    if (n > 0) exp_d = sel ? q1[0] : q0[0];
    if (sel) begin
      chk("s1_out_valid", DW'(ov1), DW'(n != 0));
      chk("s1_out_data", od1, exp_d);
      chk("s1_occupancy", DW'(occ1), DW'(n));
      chk("s1_in_ready", DW'(ir1), DW'(exp_rdy));
    end else begin
      chk("s0_out_valid", DW'(ov0), DW'(n != 0));
      chk("s0_out_data", od0, exp_d);
      chk("s0_occupancy", DW'(occ0), DW'(n));
      chk("s0_in_ready", DW'(ir0), DW'(exp_rdy));
    end
    push = iv && exp_rdy;
    pop  = (n != 0) && ordy;
    @(posedge clk);
    if (sel) begin
      if (fl) q1.delete();
      else begin
        if (pop) void'(q1.pop_front());
        if (push) q1.push_back(d);
      end
    end else begin
      if (fl) q0.delete();
      else begin
        if (pop) void'(q0.pop_front());
        if (push) q0.push_back(d);
      end
    end
    @(negedge clk);
  endtask

  // Reset pulse between clock edges; outputs must clear without any clock edge.
  task automatic mid_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s1_out_valid", DW'(ov1), '0);
    chk("rst_s1_out_data", od1, RV1);
    chk("rst_s1_occupancy", DW'(occ1), '0);
    chk("rst_s1_in_ready", DW'(ir1), DW'(1));
    chk("rst_s0_out_valid", DW'(ov0), '0);
    chk("rst_s0_out_data", od0, RV0);
    chk("rst_s0_in_ready", DW'(ir0), DW'(1));
    q1.delete();
    q0.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] a, b, c, d;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Stream 1..8 back to back, then drain
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, DW'(i), 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Stall: A,B fill both entries, C waits upstream
    a = rnd(); b = rnd(); c = rnd();
    cycle(1'b1, 1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, c, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, c, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, c, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, c, 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Flush with two held entries and a concurrent push
    cycle(1'b1, 1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, c, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Drain a single entry
    cycle(1'b1, 1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // No-skid instance: full, downstream ready, new beat D accepted same cycle
    d = rnd();
    cycle(1'b0, 1'b1, a, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, b, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, d, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset with data in flight on both instances
    cycle(1'b1, 1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, b, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, c, 1'b0, 1'b0);
    mid_reset();
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 400; i++) begin
        cycle(s[0], ($urandom % 4) != 0, rnd(), ($urandom % 3) != 0, ($urandom % 25) == 0);
      end
      repeat (3) cycle(s[0], 1'b0, '0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
